// File: rtl/sobolrng_sched.sv
// Round-robin scheduler that grants one shared sobolrng to NREQ consumers for whole epochs.
// Optional `SOBOL_EARLY_TERM_EN: the epoch ends as soon as the granted requester drops its iReq bit.
module sobolrng_sched #(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int IDXW     = $clog2(NREQ)
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [NREQ-1:0] iReq,
  input  logic            iStall,
  output logic [NREQ-1:0] oGnt,
  output logic [IDXW-1:0] oGntIdx,
  output logic            oRngClr,
  output logic            oRngEn,
  output logic [BITWIDTH-1:0] oCnt,
  output logic            oBusy,
  output logic            oDone
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} stateT;

  stateT           state, nextState;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] arbPtr;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] pickIdx;
  logic            pickValid;
  logic            earlyTerm;

`ifdef SOBOL_EARLY_TERM_EN
  assign earlyTerm = (state == RUN) && !iReq[oGntIdx];
`else
  assign earlyTerm = 1'b0;
`endif

  // In DONE the just-finished grant is already the new priority pointer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    arbPtr    = (state == DONE) ? oGntIdx : ptr;
    cand      = '0;
    pickIdx   = '0;
    pickValid = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDXW'((int'(arbPtr) + i) % NREQ);
      if (!pickValid && iReq[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  always_ff @(posedge iClk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (pickValid) nextState = CLR;
      CLR:  nextState = RUN;
      RUN: begin
        if (earlyTerm)                    nextState = DONE;
        else if (oRngEn && (oCnt == '1)) nextState = DONE;
      end
      DONE: nextState = pickValid ? CLR : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oRngClr = (state == CLR);
    oRngEn  = (state == RUN) && !iStall && !earlyTerm;
    oBusy   = (state != IDLE);
    oDone   = (state == DONE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      ptr     <= IDXW'(NREQ - 1);
      oGnt    <= '0;
      oGntIdx <= '0;
      oCnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE) ptr <= oGntIdx;
          if (pickValid) begin
            oGnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pickIdx;
            oGntIdx <= pickIdx;
          end else begin
            oGnt    <= '0;
            oGntIdx <= '0;
          end
        end
        CLR: oCnt <= '0;
        RUN: if (oRngEn) oCnt <= oCnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobolrng_sched.sv
// Directed self-checking bench for sobolrng_sched at BITWIDTH=4, NREQ=4.
// The early-termination scenario runs only when SOBOL_EARLY_TERM_EN is defined.
module tb_sobolrng_sched;

  localparam int BW = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic          iClk = 1'b0;
  logic          iRst;
  logic [NR-1:0] iReq;
  logic          iStall;
  logic [NR-1:0] oGnt;
  logic [IW-1:0] oGntIdx;
  logic          oRngClr;
  logic          oRngEn;
  logic [BW-1:0] oCnt;
  logic          oBusy;
  logic          oDone;

  int compared   = 0;
  int mismatched = 0;

  sobolrng_sched #(.BITWIDTH(BW), .NREQ(NR)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iStall(iStall),
    .oGnt(oGnt), .oGntIdx(oGntIdx), .oRngClr(oRngClr), .oRngEn(oRngEn),
    .oCnt(oCnt), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".gnt"},    32'(oGnt),    32'h0);
    check({tag, ".idx"},    32'(oGntIdx), 32'h0);
    check({tag, ".clr"},    32'(oRngClr), 32'h0);
    check({tag, ".en"},     32'(oRngEn),  32'h0);
    check({tag, ".cnt"},    32'(oCnt),    32'h0);
    check({tag, ".busy"},   32'(oBusy),   32'h0);
    check({tag, ".done"},   32'(oDone),   32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneAt;
    iRst = 1'b1; iReq = '0; iStall = 1'b0;
    tick(); tick();
    checkAllZero("reset");

    // Single requester: CLR, 16 enabled cycles counting 0..15, then DONE.
    iRst = 1'b0; iReq = 4'b0001;
    tick();
    check("t1.clrGnt", 32'(oGnt), 32'h1);
    check("t1.clr",    32'(oRngClr), 32'h1);
    check("t1.clrEn",  32'(oRngEn), 32'h0);
    check("t1.busy",   32'(oBusy), 32'h1);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t1.runEn",  32'(oRngEn), 32'h1);
      check("t1.runCnt", 32'(oCnt), 32'(k));
      check("t1.runClr", 32'(oRngClr), 32'h0);
    end
    tick();
    check("t1.done",    32'(oDone), 32'h1);
    check("t1.doneCnt", 32'(oCnt), 32'h0);
    check("t1.doneGnt", 32'(oGnt), 32'h1);
    check("t1.doneEn",  32'(oRngEn), 32'h0);

    // No request at DONE: idle indefinitely, stall toggling is irrelevant.
    iReq = '0;
    tick();
    checkAllZero("idle");
    for (int i = 0; i < 4; i++) begin
      iStall = i[0];
      tick();
      check("idle.busy", 32'(oBusy), 32'h0);
      check("idle.gnt",  32'(oGnt), 32'h0);
      check("idle.en",   32'(oRngEn), 32'h0);
    end
    iStall = 1'b0;

    // All requesting from reset: order 0,1,2,3,0, each grant held 18 cycles.
    iRst = 1'b1;
    tick();
    iRst = 1'b0; iReq = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      tick();
      check("rr.clr", 32'(oRngClr), 32'h1);
      check("rr.gnt", 32'(oGnt), 32'(1) << (e % 4));
      check("rr.idx", 32'(oGntIdx), 32'(e % 4));
      for (int c = 0; c < 16; c++) begin
        tick();
        check("rr.holdGnt", 32'(oGnt), 32'(1) << (e % 4));
        check("rr.en",      32'(oRngEn), 32'h1);
      end
      tick();
      check("rr.done",    32'(oDone), 32'h1);
      check("rr.doneGnt", 32'(oGnt), 32'(1) << (e % 4));
    end
    iReq = '0;
    tick();
    check("rr.idleBusy", 32'(oBusy), 32'h0);

    // Stall three cycles at count 5: done moves from 17 to 20 cycles after CLR.
    iReq = 4'b0001;
    tick();
    check("st.gnt", 32'(oGnt), 32'h1);
    doneAt = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      iStall = (n >= 6 && n <= 8);
      #1;
      if (n >= 6 && n <= 8) begin
        check("st.stallEn",  32'(oRngEn), 32'h0);
        check("st.stallCnt", 32'(oCnt), 32'h5);
      end
      if (n == 9) begin
        check("st.resumeEn",  32'(oRngEn), 32'h1);
        check("st.resumeCnt", 32'(oCnt), 32'h5);
      end
      if (oDone) begin
        doneAt = n;
        break;
      end
    end
    iStall = 1'b0;
    check("st.doneAt", 32'(doneAt), 32'd20);
    iReq = '0;
    tick();
    check("st.idleBusy", 32'(oBusy), 32'h0);

    // Reset mid-epoch: everything drops, no done; then requester 1 wins from ptr=3.
    iReq = 4'b0001;
    tick();
    repeat (8) tick();
    check("mr.cnt7", 32'(oCnt), 32'h7);
    iRst = 1'b1; iReq = 4'b1010;
    tick();
    checkAllZero("mr.reset");
    iRst = 1'b0;
    tick();
    check("mr.gnt", 32'(oGnt), 32'h2);
    check("mr.idx", 32'(oGntIdx), 32'h1);
    check("mr.clr", 32'(oRngClr), 32'h1);
    repeat (17) tick();
    check("mr.done",    32'(oDone), 32'h1);
    check("mr.doneIdx", 32'(oGntIdx), 32'h1);
    iReq = '0;
    tick();
    check("mr.idleBusy", 32'(oBusy), 32'h0);

`ifdef SOBOL_EARLY_TERM_EN
    // Granted requester drops out at count 9: enable drops at once, done next cycle.
    iRst = 1'b1;
    tick();
    iRst = 1'b0; iReq = 4'b0011;
    tick();
    check("et.gnt", 32'(oGnt), 32'h1);
    repeat (10) tick();
    check("et.cnt9", 32'(oCnt), 32'h9);
    check("et.en",   32'(oRngEn), 32'h1);
    iReq = 4'b0010;
    #1;
    check("et.enDrop", 32'(oRngEn), 32'h0);
    tick();
    check("et.done",    32'(oDone), 32'h1);
    check("et.doneCnt", 32'(oCnt), 32'h9);
    tick();
    check("et.nextGnt", 32'(oGnt), 32'h2);
    check("et.nextClr", 32'(oRngClr), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
